// File: rtl/vote_logger_scan_if.sv
// vote_logger_scan_if
//   Groups the vote logger's mode/vote inputs and its count/result outputs
//   into one bundle.
//   master : the side that drives mode and the vote pulses (button control / bench)
//   slave  : vote_logger_scan itself
//   Signals:
//     mode                  0 = voting, 1 = result
//     candidate_valid_vote  one-cycle vote pulses, bit i = candidate i
//     cand_votes            flattened counters, candidate i at [i*CNT_W +: CNT_W]
//     total_votes           accepted vote count
//     rejected_votes        rejected vote count (saturating)
//     winner_idx            index of winning candidate
//     winner_votes          vote count of the winner
//     tie                   winner shares the maximum with another candidate
//     result_valid          winner_idx / winner_votes / tie are valid
interface vote_logger_scan_if #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8
);
    localparam int IDX_W = ($clog2(NUM_CAND) > 1) ? $clog2(NUM_CAND) : 1;
    localparam int TOT_W = CNT_W + IDX_W;

    logic                      mode;
    logic [NUM_CAND-1:0]       candidate_valid_vote;
    logic [NUM_CAND*CNT_W-1:0] cand_votes;
    logic [TOT_W-1:0]          total_votes;
    logic [CNT_W-1:0]          rejected_votes;
    logic [IDX_W-1:0]          winner_idx;
    logic [CNT_W-1:0]          winner_votes;
    logic                      tie;
    logic                      result_valid;

    modport master (
        output mode,
        output candidate_valid_vote,
        input  cand_votes,
        input  total_votes,
        input  rejected_votes,
        input  winner_idx,
        input  winner_votes,
        input  tie,
        input  result_valid
    );

    modport slave (
        input  mode,
        input  candidate_valid_vote,
        output cand_votes,
        output total_votes,
        output rejected_votes,
        output winner_idx,
        output winner_votes,
        output tie,
        output result_valid
    );
endinterface

// File: rtl/vote_logger_scan.sv
// vote_logger_scan
//   Counts one-hot votes for NUM_CAND candidates, rejects and counts multi-hot
//   inputs, keeps a running total, and on entering result mode runs a
//   sequential scan (one candidate per cycle) to find the winner and any tie.
//
//   Ports:
//     i_clock  single clock, all state on rising edge
//     i_reset  synchronous active-high reset, dominates all inputs
//     bus      vote_logger_scan_if.slave (mode, votes in; counts, result out)
//
//   Build option:
//     VOTE_LOGGER_SATURATE_EN  defined   : a full candidate counter refuses
//                                          further votes; they count as rejected
//                              undefined : candidate counters and total wrap
//
//   state | meaning
//   IDLE  | accepting votes while mode==0; mode==1 starts a scan
//   SCAN  | comparing candidate r_scan_idx against the running best
//   DONE  | result held and valid until mode drops
module vote_logger_scan #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    vote_logger_scan_if.slave  bus
);
    localparam int IDX_W = ($clog2(NUM_CAND) > 1) ? $clog2(NUM_CAND) : 1;
    localparam int TOT_W = CNT_W + IDX_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt [NUM_CAND];
    logic [TOT_W-1:0] r_total;
    logic [CNT_W-1:0] r_rej;

    logic [IDX_W-1:0] r_scan_idx;
    logic [CNT_W-1:0] r_best;
    logic [IDX_W-1:0] r_best_idx;
    logic             r_best_tie;

    logic [IDX_W-1:0] r_win_idx;
    logic [CNT_W-1:0] r_win_votes;
    logic             r_tie;
    logic             r_valid;

    // vote decode
    logic [NUM_CAND-1:0] w_votes;
    logic [NUM_CAND-1:0] w_votes_m1;
    logic                w_vote_any;
    logic                w_vote_multi;
    logic                w_vote_one;
    logic [IDX_W-1:0]    w_vote_idx;
    logic                w_vote_en;
    logic                w_sel_full;
    logic                w_accept;
    logic                w_reject;

    assign w_votes      = bus.candidate_valid_vote;
    assign w_votes_m1   = w_votes - NUM_CAND'(1);
    assign w_vote_any   = |w_votes;
    // clearing the lowest set bit leaves something only if two or more are set
    assign w_vote_multi = w_vote_any && ((w_votes & w_votes_m1) != '0);
    assign w_vote_one   = w_vote_any && !w_vote_multi;
    assign w_vote_en    = (r_state == IDLE) && !bus.mode;

    always_comb begin
        w_vote_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (w_votes[i]) begin
                w_vote_idx = IDX_W'(i);
            end
        end
    end

    assign w_sel_full = (r_cnt[w_vote_idx] == '1);

`ifdef VOTE_LOGGER_SATURATE_EN
    assign w_accept = w_vote_en && w_vote_one && !w_sel_full;
    assign w_reject = w_vote_en && (w_vote_multi || (w_vote_one && w_sel_full));
`else
    assign w_accept = w_vote_en && w_vote_one;
    assign w_reject = w_vote_en && w_vote_multi;
`endif

    // scan step: next running best after looking at candidate r_scan_idx
    logic [CNT_W-1:0] w_cnt_k;
    logic [CNT_W-1:0] w_best_nxt;
    logic [IDX_W-1:0] w_best_idx_nxt;
    logic             w_tie_nxt;
    logic             w_scan_last;

    assign w_cnt_k     = r_cnt[r_scan_idx];
    assign w_scan_last = (r_scan_idx == LAST_IDX);

    always_comb begin
        w_best_nxt     = r_best;
        w_best_idx_nxt = r_best_idx;
        w_tie_nxt      = r_best_tie;
        if (r_scan_idx == '0) begin
            w_best_nxt     = w_cnt_k;
            w_best_idx_nxt = '0;
            w_tie_nxt      = 1'b0;
        end else if (w_cnt_k > r_best) begin
            w_best_nxt     = w_cnt_k;
            w_best_idx_nxt = r_scan_idx;
            w_tie_nxt      = 1'b0;
        end else if (w_cnt_k == r_best) begin
            // keep the earlier index so the lowest index wins a tie
            w_tie_nxt      = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= IDLE;
            for (int i = 0; i < NUM_CAND; i++) begin
                r_cnt[i] <= '0;
            end
            r_total     <= '0;
            r_rej       <= '0;
            r_scan_idx  <= '0;
            r_best      <= '0;
            r_best_idx  <= '0;
            r_best_tie  <= 1'b0;
            r_win_idx   <= '0;
            r_win_votes <= '0;
            r_tie       <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt[w_vote_idx] <= r_cnt[w_vote_idx] + CNT_W'(1);
                r_total           <= r_total + TOT_W'(1);
            end
            if (w_reject && (r_rej != '1)) begin
                r_rej <= r_rej + CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (bus.mode) begin
                        r_state    <= SCAN;
                        r_scan_idx <= '0;
                        r_best     <= '0;
                        r_best_idx <= '0;
                        r_best_tie <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!bus.mode) begin
                        r_state <= IDLE;
                    end else begin
                        r_best     <= w_best_nxt;
                        r_best_idx <= w_best_idx_nxt;
                        r_best_tie <= w_tie_nxt;
                        if (w_scan_last) begin
                            r_state     <= DONE;
                            r_win_idx   <= w_best_idx_nxt;
                            r_win_votes <= w_best_nxt;
                            r_tie       <= w_tie_nxt;
                            r_valid     <= 1'b1;
                        end else begin
                            r_scan_idx <= r_scan_idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    // winner outputs keep their last values after leaving DONE
                    if (!bus.mode) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.cand_votes = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            bus.cand_votes[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

    assign bus.total_votes    = r_total;
    assign bus.rejected_votes = r_rej;
    assign bus.winner_idx     = r_win_idx;
    assign bus.winner_votes   = r_win_votes;
    assign bus.tie            = r_tie;
    assign bus.result_valid   = r_valid;
endmodule

// File: doc/vote_logger_scan.md
Name: vote_logger_scan

Overview:
Parametrised successor to the fixed 4-candidate vote counter. It counts one-hot valid votes for NUM_CAND candidates and rejects and counts multi-hot inputs. It keeps a running total. When mode switches to result mode, a sequential scan FSM finds the winner and detects ties. It sits between the per-candidate button control modules and the result display/mux logic.

Parameters:
- NUM_CAND, 4, number of candidates (2..16).
- CNT_W, 8, width of each per-candidate counter and of the reject counter.
- Derived localparams, not overridable:
  - IDX_W = max(1, clog2(NUM_CAND)).
  - TOT_W = CNT_W + IDX_W.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = voting, 1 = result.
- candidate_valid_vote  in  NUM_CAND  one-cycle vote pulses; bit i = candidate i.
- cand_votes  out  NUM_CAND*CNT_W  flattened counters; candidate i at [i*CNT_W +: CNT_W].
- total_votes  out  TOT_W  count of accepted votes.
- rejected_votes  out  CNT_W  count of multi-hot inputs; saturates at all-ones.
- winner_idx  out  IDX_W  index of winning candidate.
- winner_votes  out  CNT_W  vote count of the winner.
- tie  out  1  winner shares the maximum count with at least one other candidate.
- result_valid  out  1  winner_idx, winner_votes and tie are valid.

Behaviour:
- Reset (synchronous, active-high, dominates all inputs): every output and counter goes to 0, FSM goes to IDLE. Reset mid-scan aborts the scan.
- FSM states: IDLE, SCAN, DONE.
- Vote acceptance, evaluated only in IDLE with mode==0:
  - Exactly one bit i set: cand i counter +1 and total_votes +1, visible the next cycle (1-cycle latency).
  - Zero bits set: no action.
  - Two or more bits set: no candidate counter changes; rejected_votes +1, saturating.
  - Every cycle is independent, so back-to-back one-hot pulses each count.
- With mode==1, or in SCAN/DONE, candidate_valid_vote is ignored entirely, including reject counting.
- IDLE -> SCAN: on any edge with mode==1.
  - Scan index clears to 0.
  - best count clears to 0, best index to 0, tie flag to 0.
- SCAN, one candidate per cycle at index k = 0..NUM_CAND-1:
  - k==0: best = count[0], idx = 0, tie = 0.
  - k>0, count[k] > best: best = count[k], idx = k, tie = 0.
  - k>0, count[k] == best: tie = 1, idx unchanged, so the lowest index wins a tie.
  - k>0, count[k] < best: no change.
  - After k = NUM_CAND-1: go to DONE; result_valid = 1 and outputs load.
- Result latency: result_valid rises NUM_CAND+1 edges after the first edge that samples mode==1.
- SCAN with mode==0: abort to IDLE; result_valid stays 0; counters are untouched.
- DONE with mode==1: hold winner_idx, winner_votes, tie and result_valid stable.
- DONE with mode==0: go to IDLE; result_valid = 0 next cycle. winner_idx, winner_votes and tie keep their last values.
- Re-entering result mode triggers a fresh full scan.
- All counts zero: winner_idx = 0, winner_votes = 0, tie = 1.
- total_votes cannot overflow unless the wrap option is active; it follows the optional feature's rules.

Optional Feature:
- Macro: VOTE_LOGGER_SATURATE_EN.
- Defined:
  - A candidate counter at all-ones ignores further votes for that candidate.
  - total_votes does not increment for such a vote.
  - The vote counts as rejected (rejected_votes +1, saturating).
- Undefined:
  - Candidate counters and total_votes wrap modulo 2^CNT_W and 2^TOT_W.
  - The vote is still accepted.
- rejected_votes saturates in both builds.

Test Plan:
1. Reset, then mode=0 and one-hot pulses 0001 x3, 0010 x1, 1000 x2 (1-cycle each, back-to-back) -> counts 3,1,0,2; total_votes=6; rejected_votes=0.
2. Mode=0, pulses 0011, 1111, 0000 -> all candidate counts unchanged; rejected_votes=2; total_votes unchanged.
3. From test 1, raise mode -> result_valid=0 for edges 1-4 and 1 at edge 5; winner_idx=0, winner_votes=3, tie=0.
   - Hold mode=1 10 cycles -> outputs stable.
   - Drop mode -> result_valid=0 next cycle.
4. Counts 2,5,5,1, raise mode -> winner_idx=1, winner_votes=5, tie=1.
   - After reset with all counts zero -> winner_idx=0, winner_votes=0, tie=1.
5. Raise mode, drop it after 2 cycles (mid-SCAN) -> result_valid never asserts, FSM back in IDLE.
   - Next one-hot 0100 vote -> candidate 2 increments.
   - Assert reset during SCAN -> all outputs 0 next cycle.
6. CNT_W=2: 5 votes for candidate 0 ->
   - With VOTE_LOGGER_SATURATE_EN: count=3, total=3, rejected=2.
   - Without the macro: count=1, total=5, rejected=0.
